// File: rtl/shunt_fringe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : shunt_fringe_ctrl_if
//  Description : Local put/get request bus and single-beat TX/RX link frame
//                streams of one split-design partition. Signal suffixes are
//                seen from the engine side (slave modport).
//  Revision    : 1.0 - initial release
// ============================================================================
interface shunt_fringe_ctrl_if #(
    parameter int DATA_W = 9,
    parameter int ID_W   = 2
);
    localparam int c_frame_w = 2 + ID_W + DATA_W;

    // Local put request (payload towards a remote slot)
    logic                 put_req_i;
    logic [ID_W-1:0]      put_sig_i;
    logic                 put_type_i;
    logic [DATA_W-1:0]    put_data_i;
    logic                 put_busy_o;
    logic                 put_done_o;
    logic                 put_err_o;

    // Local get request (latest payload of a local slot)
    logic                 get_req_i;
    logic [ID_W-1:0]      get_sig_i;
    logic                 get_ack_o;
    logic                 get_ok_o;
    logic [DATA_W-1:0]    get_data_o;

    // Link frames {eos, type, sig, data}
    logic                 tx_valid_o;
    logic                 tx_ready_i;
    logic [c_frame_w-1:0] tx_data_o;
    logic                 rx_valid_i;
    logic [c_frame_w-1:0] rx_data_i;

    // Requester / link-partner side
    modport master (
        output put_req_i, put_sig_i, put_type_i, put_data_i,
        input  put_busy_o, put_done_o, put_err_o,
        output get_req_i, get_sig_i,
        input  get_ack_o, get_ok_o, get_data_o,
        input  tx_valid_o, tx_data_o,
        output tx_ready_i,
        output rx_valid_i, rx_data_i
    );

    // Transaction engine side
    modport slave (
        input  put_req_i, put_sig_i, put_type_i, put_data_i,
        output put_busy_o, put_done_o, put_err_o,
        input  get_req_i, get_sig_i,
        output get_ack_o, get_ok_o, get_data_o,
        output tx_valid_o, tx_data_o,
        input  tx_ready_i,
        input  rx_valid_i, rx_data_i
    );
endinterface
`default_nettype wire

// File: rtl/shunt_fringe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shunt_fringe_ctrl
//  Description : Transaction engine for one partition of a co-simulated split
//                design. Sends put payloads and end-of-simulation over a TX
//                frame stream, stores RX payloads in a per-slot table served
//                by local gets, and freezes the mission clock while a get
//                finds no fresh data (guarded by a watchdog).
//  Revision    : 1.0 - initial release
// ============================================================================
module shunt_fringe_ctrl #(
    parameter int DATA_W   = 9,
    parameter int N_SIG    = 4,
    parameter int ID_W     = 2,
    parameter int WDOG_MAX = 10000,
    parameter int TIME_W   = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    shunt_fringe_ctrl_if.slave  bus,
    input  logic                eos_i,
    output logic                freeze_o,
    output logic                wdog_err_o,
    output logic                rx_err_o,
    output logic [1:0]          status_o,
    output logic [TIME_W-1:0]   time_o
);

    localparam int c_frame_w = 2 + ID_W + DATA_W;
    localparam int c_idx_w   = (N_SIG > 1) ? $clog2(N_SIG) : 1;
    localparam int c_wdog_w  = $clog2(WDOG_MAX + 1);

    // Slot ids are compared one bit wider so N_SIG = 2**ID_W is representable
    localparam logic [ID_W:0]          c_n_sig      = (ID_W + 1)'(N_SIG);
    localparam logic [c_wdog_w-1:0]    c_wdog_max   = c_wdog_w'(WDOG_MAX);
    localparam logic [c_wdog_w-1:0]    c_wdog_last  = c_wdog_w'(WDOG_MAX - 1);
    localparam logic [c_frame_w-1:0]   c_eos_frame  = {1'b1, {(c_frame_w - 1){1'b0}}};
    localparam logic [TIME_W-1:0]      c_time_max   = {TIME_W{1'b1}};

    localparam logic [1:0] c_st_inactive = 2'd0;
    localparam logic [1:0] c_st_active   = 2'd1;
    localparam logic [1:0] c_st_eos_pend = 2'd2;
    localparam logic [1:0] c_st_done     = 2'd3;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_PUT  = 2'd1,
        TX_EOS  = 2'd2,
        TX_DONE = 2'd3
    } tx_state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    tx_state_e              r_tx_state;
    logic [c_frame_w-1:0]   r_frame;
    logic                   r_put_done;
    logic                   r_put_err;
    logic                   r_eos_pend;
    logic                   r_active;
    logic [TIME_W-1:0]      r_time;

    logic [DATA_W-1:0]      r_payload [N_SIG];
    logic                   r_valid   [N_SIG];

    logic                   r_get_ack;
    logic                   r_get_ok;
    logic [DATA_W-1:0]      r_get_data;
    logic                   r_freeze;
    logic [c_wdog_w-1:0]    r_wdog_cnt;
    logic                   r_wdog_err;
    logic                   r_rx_err;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    tx_state_e              w_tx_next;
    logic                   w_put_fire;

    logic                   w_rx_eos;
    logic [ID_W-1:0]        w_rx_sig;
    logic [DATA_W-1:0]      w_rx_data;
    logic [c_idx_w-1:0]     w_rx_idx;
    logic                   w_rx_in_range;
    logic                   w_rx_eos_hit;
    logic                   w_rx_wr;

    logic                   w_put_in_range;
    logic                   w_put_accept;
    logic                   w_put_reject;

    logic [c_idx_w-1:0]     w_get_idx;
    logic                   w_get_in_range;
    logic                   w_get_hit;
    logic [DATA_W-1:0]      w_get_rdata;

    assign w_rx_eos      = bus.rx_data_i[c_frame_w-1];
    assign w_rx_sig      = bus.rx_data_i[DATA_W +: ID_W];
    assign w_rx_data     = bus.rx_data_i[DATA_W-1:0];
    assign w_rx_idx      = w_rx_sig[c_idx_w-1:0];
    assign w_rx_in_range = ({1'b0, w_rx_sig} < c_n_sig);
    assign w_rx_eos_hit  = bus.rx_valid_i && w_rx_eos;
    assign w_rx_wr       = bus.rx_valid_i && !w_rx_eos && w_rx_in_range;

    // A put is taken only from IDLE, before any EOS is pending, and not in
    // the cycle a peer EOS tears the link down.
    assign w_put_in_range = ({1'b0, bus.put_sig_i} < c_n_sig);
    assign w_put_accept   = bus.put_req_i && (r_tx_state == TX_IDLE) && !r_eos_pend
                            && w_put_in_range && !w_rx_eos_hit;
    assign w_put_reject   = bus.put_req_i && !w_put_accept;

    assign w_get_idx      = bus.get_sig_i[c_idx_w-1:0];
    assign w_get_in_range = ({1'b0, bus.get_sig_i} < c_n_sig);
    assign w_get_hit      = w_get_in_range && r_valid[w_get_idx];
    assign w_get_rdata    = w_get_in_range ? r_payload[w_get_idx] : '0;

    // ------------------------------------------------------------------
    // TX frame FSM
    // ------------------------------------------------------------------

    // TX state register; reset drops tx_valid_o without waiting for a clock
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    // TX next state: put handshake, then EOS frame once pending, peer EOS overrides all
    always_comb begin
        w_tx_next  = r_tx_state;
        w_put_fire = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_put_accept) begin
                    w_tx_next = TX_PUT;
                end else if (r_eos_pend) begin
                    w_tx_next = TX_EOS;
                end
            end
            TX_PUT: begin
                if (bus.tx_ready_i) begin
                    w_put_fire = 1'b1;
                    w_tx_next  = (r_eos_pend || eos_i) ? TX_EOS : TX_IDLE;
                end
            end
            TX_EOS: begin
                if (bus.tx_ready_i) begin
                    w_tx_next = TX_DONE;
                end
            end
            default: begin
                w_tx_next = TX_DONE;
            end
        endcase
        if (w_rx_eos_hit) begin
            w_tx_next  = TX_DONE;
            w_put_fire = 1'b0;
        end
    end

    // Put frame latch, put completion/rejection pulses and EOS bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frame    <= '0;
            r_put_done <= 1'b0;
            r_put_err  <= 1'b0;
            r_eos_pend <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            if (w_put_accept) begin
                r_frame <= {1'b0, bus.put_type_i, bus.put_sig_i, bus.put_data_i};
            end
            r_put_done <= w_put_fire;
            r_put_err  <= w_put_reject;
            if (eos_i) begin
                r_eos_pend <= 1'b1;
            end
            r_active <= 1'b1;
        end
    end

    // Saturating cycle counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_time <= '0;
        end else if (r_time != c_time_max) begin
            r_time <= r_time + TIME_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Slot table and get path
    // ------------------------------------------------------------------

    // Slot table: an RX write of a slot wins over the clear caused by a
    // successful get of the same slot in the same cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_SIG; i++) begin
                r_payload[i] <= '0;
                r_valid[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_SIG; i++) begin
                if (w_rx_wr && (w_rx_idx == c_idx_w'(i))) begin
                    r_payload[i] <= w_rx_data;
                    r_valid[i]   <= 1'b1;
                end else if (bus.get_req_i && w_get_hit && (w_get_idx == c_idx_w'(i))) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Get response: one-cycle latency, result held until the next ack;
    // freeze follows the freshness of the latest answer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_get_ack  <= 1'b0;
            r_get_ok   <= 1'b0;
            r_get_data <= '0;
            r_freeze   <= 1'b0;
        end else begin
            r_get_ack <= bus.get_req_i;
            if (bus.get_req_i) begin
                r_get_ok   <= w_get_hit;
                r_get_data <= w_get_rdata;
                r_freeze   <= !w_get_hit;
            end
        end
    end

    // Watchdog over consecutive frozen cycles; the error is sticky
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (!r_freeze) begin
                r_wdog_cnt <= '0;
            end else if (r_wdog_cnt != c_wdog_max) begin
                r_wdog_cnt <= r_wdog_cnt + c_wdog_w'(1);
            end
            if (r_freeze && (r_wdog_cnt >= c_wdog_last)) begin
                r_wdog_err <= 1'b1;
            end
        end
    end

    // Out-of-range RX data frames are dropped and flagged
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_err <= 1'b0;
        end else begin
            r_rx_err <= bus.rx_valid_i && !w_rx_eos && !w_rx_in_range;
        end
    end

    // Status: DONE dominates a pending EOS, which dominates plain activity
    always_comb begin
        status_o = c_st_inactive;
        if (r_tx_state == TX_DONE) begin
            status_o = c_st_done;
        end else if (r_eos_pend) begin
            status_o = c_st_eos_pend;
        end else if (r_active) begin
            status_o = c_st_active;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.put_busy_o = (r_tx_state == TX_PUT);
    assign bus.put_done_o = r_put_done;
    assign bus.put_err_o  = r_put_err;
    assign bus.get_ack_o  = r_get_ack;
    assign bus.get_ok_o   = r_get_ok;
    assign bus.get_data_o = r_get_data;
    assign bus.tx_valid_o = (r_tx_state == TX_PUT) || (r_tx_state == TX_EOS);
    assign bus.tx_data_o  = (r_tx_state == TX_EOS) ? c_eos_frame : r_frame;

    assign freeze_o   = r_freeze;
    assign wdog_err_o = r_wdog_err;
    assign rx_err_o   = r_rx_err;
    assign time_o     = r_time;

endmodule
`default_nettype wire

// File: tb/tb_shunt_fringe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shunt_fringe_ctrl
//  Description : Self-checking bench for shunt_fringe_ctrl: directed vector
//                table for the slot table/get path, hand-written put, EOS,
//                watchdog and reset sequences, and random RX/get traffic
//                against a slot-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shunt_fringe_ctrl;

    localparam int DATA_W   = 9;
    localparam int N_SIG    = 4;
    localparam int ID_W     = 3;
    localparam int WDOG_MAX = 16;
    localparam int TIME_W   = 32;
    localparam int FW       = 2 + ID_W + DATA_W;
    localparam int NV       = 14;
    localparam int NRAND    = 300;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              eos_i;
    logic              freeze_o;
    logic              wdog_err_o;
    logic              rx_err_o;
    logic [1:0]        status_o;
    logic [TIME_W-1:0] time_o;

    int n_vec = 0;
    int n_err = 0;

    shunt_fringe_ctrl_if #(.DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    shunt_fringe_ctrl #(
        .DATA_W   (DATA_W),
        .N_SIG    (N_SIG),
        .ID_W     (ID_W),
        .WDOG_MAX (WDOG_MAX),
        .TIME_W   (TIME_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .bus        (bus),
        .eos_i      (eos_i),
        .freeze_o   (freeze_o),
        .wdog_err_o (wdog_err_o),
        .rx_err_o   (rx_err_o),
        .status_o   (status_o),
        .time_o     (time_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              rx;
        logic [ID_W-1:0] rx_sig;
        logic [8:0]      rx_dat;
        bit              get;
        logic [ID_W-1:0] get_sig;
        bit              e_ack;
        bit              e_ok;
        logic [8:0]      e_data;
        bit              e_freeze;
        bit              e_rx_err;
    } vec_t;

    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.put_req_i  = 1'b0;
        bus.put_sig_i  = '0;
        bus.put_type_i = 1'b0;
        bus.put_data_i = '0;
        bus.get_req_i  = 1'b0;
        bus.get_sig_i  = '0;
        bus.tx_ready_i = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = '0;
        eos_i          = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    function automatic logic [FW-1:0] mk_frame(input bit eos, input bit typ,
                                               input logic [ID_W-1:0] sig,
                                               input logic [DATA_W-1:0] d);
        return {eos, typ, sig, d};
    endfunction

    task automatic start_put(input logic [ID_W-1:0] sig, input bit typ, input logic [DATA_W-1:0] d);
        bus.put_req_i  = 1'b1;
        bus.put_sig_i  = sig;
        bus.put_type_i = typ;
        bus.put_data_i = d;
        tick();
        bus.put_req_i  = 1'b0;
    endtask

    // Safety net in case the run ever stalls
    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0]     exp_frame;
        logic [DATA_W-1:0] m_payload [N_SIG];
        bit                m_valid   [N_SIG];
        bit                m_ok;
        logic [DATA_W-1:0] m_data;
        bit                m_freeze;
        bit                m_werr;
        int                m_run;

        vecs[0]  = '{1'b1, 3'd2, 9'h0FF, 1'b0, 3'd0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 9'h000, 1'b1, 3'd2, 1'b1, 1'b1, 9'h0FF, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 9'h000, 1'b1, 3'd2, 1'b1, 1'b0, 9'h0FF, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 3'd0, 9'h011, 1'b0, 3'd0, 1'b0, 1'b0, 9'h0FF, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 3'd0, 9'h022, 1'b1, 3'd0, 1'b1, 1'b1, 9'h011, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 3'd0, 9'h000, 1'b1, 3'd0, 1'b1, 1'b1, 9'h022, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 3'd7, 9'h055, 1'b0, 3'd0, 1'b0, 1'b1, 9'h022, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 3'd0, 9'h000, 1'b1, 3'd5, 1'b1, 1'b0, 9'h000, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 9'h000, 1'b1, 3'd3, 1'b1, 1'b0, 9'h000, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 3'd3, 9'h1C3, 1'b1, 3'd1, 1'b1, 1'b0, 9'h000, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 3'd0, 9'h000, 1'b1, 3'd3, 1'b1, 1'b1, 9'h1C3, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 3'd1, 9'h100, 1'b0, 3'd0, 1'b0, 1'b1, 9'h1C3, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 3'd1, 9'h101, 1'b0, 3'd0, 1'b0, 1'b1, 9'h1C3, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 3'd0, 9'h000, 1'b1, 3'd1, 1'b1, 1'b1, 9'h101, 1'b0, 1'b0};

        // ---------------- reset state and idle time base ----------------
        rst_ni = 1'b0;
        idle_inputs();
        #2;
        chk("rst_status", status_o, 2'd0);
        chk("rst_time", time_o, 0);
        chk("rst_tx_valid", bus.tx_valid_o, 0);
        chk("rst_busy", bus.put_busy_o, 0);
        chk("rst_freeze", freeze_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        chk("rel_status", status_o, 2'd0);
        repeat (10) tick();
        chk("idle_time", time_o, 10);
        chk("idle_status", status_o, 2'd1);
        chk("idle_wdog", wdog_err_o, 0);
        chk("idle_ack", bus.get_ack_o, 0);
        chk("idle_rx_err", rx_err_o, 0);

        // ---------------- put with backpressure ----------------
        exp_frame = mk_frame(1'b0, 1'b0, 3'd1, 9'h1A5);
        start_put(3'd1, 1'b0, 9'h1A5);
        chk("put_busy", bus.put_busy_o, 1);
        chk("put_tx_valid", bus.tx_valid_o, 1);
        chk("put_frame", bus.tx_data_o, exp_frame);
        start_put(3'd2, 1'b1, 9'h0AA);
        chk("put_busy_err", bus.put_err_o, 1);
        chk("put_busy_frame", bus.tx_data_o, exp_frame);
        tick();
        chk("put_err_pulse", bus.put_err_o, 0);
        chk("put_hold_frame", bus.tx_data_o, exp_frame);
        chk("put_no_done", bus.put_done_o, 0);
        bus.tx_ready_i = 1'b1;
        tick();
        bus.tx_ready_i = 1'b0;
        chk("put_done", bus.put_done_o, 1);
        chk("put_busy_drop", bus.put_busy_o, 0);
        chk("put_tx_drop", bus.tx_valid_o, 0);
        tick();
        chk("put_done_pulse", bus.put_done_o, 0);
        start_put(3'd5, 1'b0, 9'h001);
        chk("put_range_err", bus.put_err_o, 1);
        chk("put_range_busy", bus.put_busy_o, 0);

        // ---------------- slot table / get vector table ----------------
        for (int i = 0; i < NV; i++) begin
            bus.rx_valid_i = vecs[i].rx;
            bus.rx_data_i  = mk_frame(1'b0, 1'b0, vecs[i].rx_sig, vecs[i].rx_dat);
            bus.get_req_i  = vecs[i].get;
            bus.get_sig_i  = vecs[i].get_sig;
            tick();
            bus.rx_valid_i = 1'b0;
            bus.get_req_i  = 1'b0;
            chk($sformatf("v%0d_ack", i), bus.get_ack_o, vecs[i].e_ack);
            chk($sformatf("v%0d_ok", i), bus.get_ok_o, vecs[i].e_ok);
            chk($sformatf("v%0d_data", i), bus.get_data_o, vecs[i].e_data);
            chk($sformatf("v%0d_freeze", i), freeze_o, vecs[i].e_freeze);
            chk($sformatf("v%0d_rx_err", i), rx_err_o, vecs[i].e_rx_err);
        end

        // ---------------- watchdog ----------------
        do_reset();
        m_run  = 0;
        m_werr = 1'b0;
        for (int k = 0; k < WDOG_MAX + 4; k++) begin
            bus.get_req_i = 1'b1;
            bus.get_sig_i = 3'd3;
            tick();
            m_werr = m_werr || (m_run >= WDOG_MAX);
            chk("wd_freeze", freeze_o, 1);
            chk("wd_err", wdog_err_o, m_werr);
            m_run++;
        end
        bus.get_req_i  = 1'b0;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = mk_frame(1'b0, 1'b0, 3'd3, 9'h044);
        tick();
        bus.rx_valid_i = 1'b0;
        bus.get_req_i  = 1'b1;
        tick();
        bus.get_req_i  = 1'b0;
        chk("wd_get_ok", bus.get_ok_o, 1);
        chk("wd_get_data", bus.get_data_o, 9'h044);
        chk("wd_unfreeze", freeze_o, 0);
        tick();
        chk("wd_sticky", wdog_err_o, 1);

        // ---------------- EOS behind a pending put ----------------
        do_reset();
        start_put(3'd2, 1'b1, 9'h033);
        chk("eos_put_frame", bus.tx_data_o, mk_frame(1'b0, 1'b1, 3'd2, 9'h033));
        eos_i = 1'b1;
        tick();
        eos_i = 1'b0;
        chk("eos_pend_status", status_o, 2'd2);
        chk("eos_pend_busy", bus.put_busy_o, 1);
        bus.tx_ready_i = 1'b1;
        tick();
        bus.tx_ready_i = 1'b0;
        chk("eos_put_done", bus.put_done_o, 1);
        chk("eos_busy_drop", bus.put_busy_o, 0);
        chk("eos_tx_valid", bus.tx_valid_o, 1);
        chk("eos_frame", bus.tx_data_o, mk_frame(1'b1, 1'b0, 3'd0, 9'h000));
        tick();
        chk("eos_frame_hold", bus.tx_data_o, mk_frame(1'b1, 1'b0, 3'd0, 9'h000));
        chk("eos_status_hold", status_o, 2'd2);
        bus.tx_ready_i = 1'b1;
        tick();
        bus.tx_ready_i = 1'b0;
        chk("eos_done_status", status_o, 2'd3);
        chk("eos_done_tx", bus.tx_valid_o, 0);
        start_put(3'd1, 1'b0, 9'h0F0);
        chk("eos_put_err", bus.put_err_o, 1);
        chk("eos_put_idle", bus.tx_valid_o, 0);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = mk_frame(1'b0, 1'b0, 3'd7, 9'h077);
        tick();
        bus.rx_valid_i = 1'b0;
        chk("eos_rx_err", rx_err_o, 1);
        tick();
        chk("eos_rx_err_pulse", rx_err_o, 0);
        chk("eos_terminal", status_o, 2'd3);

        // ---------------- peer EOS abandons an in-flight put ----------------
        do_reset();
        start_put(3'd0, 1'b0, 9'h155);
        chk("ab_busy", bus.put_busy_o, 1);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = mk_frame(1'b1, 1'b0, 3'd0, 9'h000);
        tick();
        bus.rx_valid_i = 1'b0;
        chk("ab_status", status_o, 2'd3);
        chk("ab_tx_valid", bus.tx_valid_o, 0);
        chk("ab_busy_drop", bus.put_busy_o, 0);
        bus.tx_ready_i = 1'b1;
        tick();
        bus.tx_ready_i = 1'b0;
        chk("ab_no_done", bus.put_done_o, 0);

        // ---------------- asynchronous reset mid-transfer ----------------
        do_reset();
        start_put(3'd3, 1'b1, 9'h0C3);
        chk("ar_tx_valid", bus.tx_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("ar_tx_drop", bus.tx_valid_o, 0);
        chk("ar_status", status_o, 2'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // ---------------- random RX/get traffic vs slot model ----------------
        do_reset();
        for (int s = 0; s < N_SIG; s++) begin
            m_payload[s] = '0;
            m_valid[s]   = 1'b0;
        end
        m_ok     = 1'b0;
        m_data   = '0;
        m_freeze = 1'b0;
        m_werr   = 1'b0;
        m_run    = 0;
        for (int n = 0; n < NRAND; n++) begin
            bit              rx, get;
            logic [ID_W-1:0] rsig, gsig;
            logic [8:0]      rdat;
            rx   = ($urandom % 2) == 0;
            rsig = ID_W'($urandom % 8);
            rdat = 9'($urandom % 512);
            get  = ($urandom % 3) != 0;
            gsig = ID_W'($urandom % 6);
            bus.rx_valid_i = rx;
            bus.rx_data_i  = mk_frame(1'b0, 1'($urandom % 2), rsig, rdat);
            bus.get_req_i  = get;
            bus.get_sig_i  = gsig;
            tick();
            if (get) begin
                if (gsig < N_SIG) begin
                    m_ok   = m_valid[gsig];
                    m_data = m_payload[gsig];
                    m_valid[gsig] = 1'b0;
                end else begin
                    m_ok   = 1'b0;
                    m_data = '0;
                end
                m_freeze = !m_ok;
            end
            if (rx && rsig < N_SIG) begin
                m_payload[rsig] = rdat;
                m_valid[rsig]   = 1'b1;
            end
            m_werr = m_werr || (m_run >= WDOG_MAX);
            m_run  = m_freeze ? m_run + 1 : 0;
            chk("rnd_ack", bus.get_ack_o, get);
            chk("rnd_ok", bus.get_ok_o, m_ok);
            chk("rnd_data", bus.get_data_o, m_data);
            chk("rnd_freeze", freeze_o, m_freeze);
            chk("rnd_rx_err", rx_err_o, rx && (rsig >= N_SIG));
            chk("rnd_wdog", wdog_err_o, m_werr);
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
